// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Optional error counter is enabled with DMEM_ERR_CNT_EN (see dmem_responder).
package dmem_pkg;

    localparam int unsigned MAX_LATENCY = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Misaligned, illegal-size or out-of-range access.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                        input int unsigned depth);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:  bad = addr[0];
            SIZE_W:  bad = (addr[1:0] != 2'b00);
            SIZE_X:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store byte-enables and replicated data, load lane select and extension.
// Purely combinational.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rword >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        case (size)
            SIZE_B: begin
                rdata = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                rdata = rword;
            end
            default: begin
                rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target with fixed response latency (1..MAX_LATENCY).
// Define DMEM_ERR_CNT_EN to add a saturating err_cnt output counting rejected accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    logic [31:0]    mem [DEPTH];
    state_e         state;
    logic [CNT_W-1:0] cnt;

    logic [AW-1:0]  word_idx;
    logic           acc_err;
    logic           accept;
    logic           wr_en;
    logic [31:0]    rword;
    logic [3:0]     be;
    logic [31:0]    wdata_rep;
    logic [31:0]    load_data;

    always_comb begin
        word_idx = req_addr[AW+1:2];
        acc_err  = access_err(req_size, req_addr, DEPTH);
        accept   = req_valid && req_ready && !rst;
        wr_en    = accept && req_we && !acc_err;
        rword    = acc_err ? 32'h0 : mem[word_idx];
    end

    dmem_lane_fmt u_lane_fmt (
        .size        (req_size),
        .addr_lo     (req_addr[1:0]),
        .wdata       (req_wdata),
        .is_unsigned (req_unsigned),
        .rword       (rword),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata       (load_data)
    );

    // RAM contents survive reset; only the lanes selected by be are written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Response payload is captured here and held until the handshake.
                        rsp_rdata <= (acc_err || req_we) ? 32'h0 : load_data;
                        rsp_err   <= acc_err;
                        req_ready <= 1'b0;
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'h0;
        end else if (accept && acc_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 1 and 3), a byte-level reference model,
// directed literal checks and randomized traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT0  = 1;
    localparam int unsigned LAT1  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_cnt [2];
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid[0]),
        .req_ready    (req_ready[0]),
        .req_we       (req_we[0]),
        .req_addr     (req_addr[0]),
        .req_wdata    (req_wdata[0]),
        .req_size     (req_size[0]),
        .req_unsigned (req_unsigned[0]),
        .rsp_valid    (rsp_valid[0]),
        .rsp_ready    (rsp_ready[0]),
        .rsp_rdata    (rsp_rdata[0]),
        .rsp_err      (rsp_err[0])
`ifdef DMEM_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt[0])
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid[1]),
        .req_ready    (req_ready[1]),
        .req_we       (req_we[1]),
        .req_addr     (req_addr[1]),
        .req_wdata    (req_wdata[1]),
        .req_size     (req_size[1]),
        .req_unsigned (req_unsigned[1]),
        .rsp_valid    (rsp_valid[1]),
        .rsp_ready    (rsp_ready[1]),
        .rsp_rdata    (rsp_rdata[1]),
        .rsp_err      (rsp_err[1])
`ifdef DMEM_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte-addressed memory plus one pending response per instance.
    logic [7:0]  mmem [2][DEPTH*4];
    bit          m_busy [2];
    int          m_age [2];
    logic [31:0] m_rdata [2];
    bit          m_err [2];
    bit          m_rstd [2];
    int          m_errcnt [2];
    bit          m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_accept(input int k);
        logic [31:0] a;
        logic [31:0] v;
        int          n;
        bit          e;
        a = req_addr[k];
        n = 1 << req_size[k];
        e = (req_size[k] == 2'b11) || ((a % n) != 0) || ((a / 4) >= DEPTH);
        m_err[k]   = e;
        m_rdata[k] = 32'h0;
        if (!e && req_we[k]) begin
            for (int i = 0; i < n; i++) mmem[k][a + i] = req_wdata[k][8*i +: 8];
        end else if (!e) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mmem[k][a + i]) << (8 * i));
            if (n < 4 && !req_unsigned[k] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
            m_rdata[k] = v;
        end
        if (e && m_errcnt[k] < 65535) m_errcnt[k]++;
        m_busy[k] = 1'b1;
        m_age[k]  = 1;
        m_rstd[k] = 1'b0;
    endtask

    // Compare at the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_live) begin
                if (!m_busy[k]) begin
                    chk($sformatf("dut%0d idle req_ready", k), req_ready[k], 1);
                    chk($sformatf("dut%0d idle rsp_valid", k), rsp_valid[k], 0);
                    if (m_rstd[k]) begin
                        chk($sformatf("dut%0d reset rsp_rdata", k), rsp_rdata[k], 0);
                        chk($sformatf("dut%0d reset rsp_err", k), rsp_err[k], 0);
                    end
                end else if (m_age[k] >= lat(k)) begin
                    chk($sformatf("dut%0d resp req_ready", k), req_ready[k], 0);
                    chk($sformatf("dut%0d resp rsp_valid", k), rsp_valid[k], 1);
                    chk($sformatf("dut%0d resp rsp_rdata", k), rsp_rdata[k], m_rdata[k]);
                    chk($sformatf("dut%0d resp rsp_err", k), rsp_err[k], m_err[k]);
                end else begin
                    chk($sformatf("dut%0d wait req_ready", k), req_ready[k], 0);
                    chk($sformatf("dut%0d wait rsp_valid", k), rsp_valid[k], 0);
                end
`ifdef DMEM_ERR_CNT_EN
                chk($sformatf("dut%0d err_cnt", k), err_cnt[k], m_errcnt[k]);
`endif
            end
            if (rst) begin
                m_busy[k]   = 1'b0;
                m_rstd[k]   = 1'b1;
                m_errcnt[k] = 0;
            end else if (m_live) begin
                if (!m_busy[k]) begin
                    if (req_valid[k]) model_accept(k);
                end else if (m_age[k] >= lat(k) && rsp_ready[k]) begin
                    m_busy[k] = 1'b0;
                end else begin
                    m_age[k]++;
                end
            end
        end
        if (rst) m_live = 1'b1;
    end

    task automatic txn(input int k, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                       input int delay, output logic [31:0] rdata, output logic err,
                       output int lat_seen);
        int t;
        int waited;
        bit done;
        rdata    = 32'h0;
        err      = 1'b0;
        lat_seen = 0;
        @(posedge clk); #1;
        req_valid[k]    = 1'b1;
        req_we[k]       = we;
        req_addr[k]     = addr;
        req_wdata[k]    = wdata;
        req_size[k]     = size;
        req_unsigned[k] = uns;
        t = 0;
        while (req_ready[k] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            chk($sformatf("dut%0d accept timeout", k), 0, 1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat_seen = 1;
        waited   = 0;
        done     = 1'b0;
        t        = 0;
        while (!done && t < 60) begin
            if (rsp_valid[k] === 1'b1) begin
                req_valid[k] = 1'b0;
                rdata = rsp_rdata[k];
                err   = rsp_err[k];
                if (waited >= delay) begin
                    rsp_ready[k] = 1'b1;
                    @(posedge clk); #1;
                    rsp_ready[k] = 1'b0;
                    done = 1'b1;
                end else begin
                    rsp_ready[k] = 1'b0;
                    waited++;
                end
            end else begin
                lat_seen++;
                // Noise on the request side while busy must be ignored.
                req_valid[k]    = 1'($urandom_range(0, 1));
                req_we[k]       = 1'($urandom_range(0, 1));
                req_addr[k]     = $urandom & 32'h3F;
                req_wdata[k]    = $urandom;
                req_size[k]     = 2'($urandom_range(0, 3));
                rsp_ready[k]    = 1'($urandom_range(0, 1));
            end
            if (!done) begin
                @(posedge clk); #1;
                t++;
            end
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b0;
        if (!done) chk($sformatf("dut%0d response timeout", k), 0, 1);
    endtask

    task automatic preamble(input int k);
        logic [31:0] r;
        logic        e;
        int          l;
        for (int w = 0; w < 16; w++) txn(k, 1, w * 4, $urandom, 2'b10, 0, 0, r, e, l);
        for (int w = DEPTH - 4; w < DEPTH; w++) txn(k, 1, w * 4, $urandom, 2'b10, 0, 0, r, e, l);
    endtask

    task automatic rand_run(input int k, input int n);
        logic [31:0] r;
        logic [31:0] addr;
        logic        e;
        logic [1:0]  size;
        int          l;
        int          w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            w    = ($urandom_range(0, 4) == 0) ? (DEPTH - 4 + $urandom_range(0, 3))
                                               : $urandom_range(0, 15);
            addr = w * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h0000_1000;
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            txn(k, 1'($urandom_range(0, 1)), addr, $urandom, size, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), r, e, l);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          l;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k]    = 1'b0;
            req_we[k]       = 1'b0;
            req_addr[k]     = 32'h0;
            req_wdata[k]    = 32'h0;
            req_size[k]     = 2'b00;
            req_unsigned[k] = 1'b0;
            rsp_ready[k]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", req_ready[0], 1);
        chk("reset rsp_valid", rsp_valid[1], 0);
        rst = 1'b0;

        fork
            preamble(0);
            preamble(1);
        join

        // Directed sequence on the LATENCY=1 instance.
        txn(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, r, e, l);
        chk("word store err", e, 0);
        chk("word store rdata", r, 0);
        chk("word store latency", l, 1);
        txn(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("word load", r, 32'hDEADBEEF);
        txn(0, 1, 32'h13, 32'h0000_0080, 2'b00, 0, 0, r, e, l);
        txn(0, 0, 32'h13, 32'h0, 2'b00, 0, 0, r, e, l);
        chk("byte load signed", r, 32'hFFFFFF80);
        txn(0, 0, 32'h13, 32'h0, 2'b00, 1, 0, r, e, l);
        chk("byte load unsigned", r, 32'h00000080);
        txn(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("word after byte store", r, 32'h80ADBEEF);
        txn(0, 0, 32'h11, 32'h0, 2'b01, 0, 0, r, e, l);
        chk("misaligned half err", e, 1);
        chk("misaligned half rdata", r, 0);
        txn(0, 1, 32'h12, 32'h11111111, 2'b10, 0, 0, r, e, l);
        chk("misaligned word store err", e, 1);
        txn(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("ram unchanged after bad store", r, 32'h80ADBEEF);
        txn(0, 0, 32'h1000, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("out of range err", e, 1);
        chk("out of range latency", l, 1);
`ifdef DMEM_ERR_CNT_EN
        chk("err_cnt after three errors", err_cnt[0], 3);
`endif

        // LATENCY=3 timing with response held off for four cycles.
        txn(1, 1, 32'h20, 32'h12345678, 2'b10, 0, 0, r, e, l);
        txn(1, 0, 32'h20, 32'h0, 2'b10, 0, 4, r, e, l);
        chk("lat3 load data", r, 32'h12345678);
        chk("lat3 latency", l, 3);
        txn(1, 0, 32'h22, 32'h0, 2'b01, 1, 0, r, e, l);
        chk("lat3 upper half unsigned", r, 32'h00001234);
        txn(0, 1, 32'h20, 32'h0BADF00D, 2'b10, 0, 0, r, e, l);

        // Reset while dut1 is in its wait phase; dut0 sees a store on the reset edge.
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h20;
        req_size[1]  = 2'b10;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("in wait rsp_valid", rsp_valid[1], 0);
        chk("in wait req_ready", req_ready[1], 0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hFFFFFFFF;
        req_size[0]  = 2'b10;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid[0] = 1'b0;
        chk("post-rst rsp_valid", rsp_valid[1], 0);
        chk("post-rst req_ready", req_ready[1], 1);
        chk("post-rst rsp_rdata", rsp_rdata[1], 0);
`ifdef DMEM_ERR_CNT_EN
        chk("err_cnt after rst", err_cnt[0], 0);
`endif
        repeat (5) @(posedge clk);
        txn(1, 0, 32'h20, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("ram kept across rst", r, 32'h12345678);
        txn(0, 0, 32'h20, 32'h0, 2'b10, 0, 0, r, e, l);
        chk("store on rst edge dropped", r, 32'h0BADF00D);

        fork
            rand_run(0, 150);
            rand_run(1, 150);
        join

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
